movimento_posizione: RTL

Upstream stage of the rectangle/frame hit-test blocks: produces the centre coordinates X_POS/Y_POS that those blocks compare against the scan coordinates.
- Once per video frame it advances the centre by a fixed step.
- Horizontal motion wraps around the screen width; vertical motion bounces off the top/bottom limits.
- Direction changes come from board push-buttons.
- Outputs change only during blanking, so every pixel of a frame sees one stable position.

---
 rtl/movimento_posizione_pkg.sv | 26 ++
 rtl/movimento_posizione_sincronizzatore_impulso.sv | 43 ++++
 rtl/movimento_posizione.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/movimento_posizione_pkg.sv
// Shared types and helpers for the per-frame position mover:
// FSM states, direction encodings and the vertical-limit derivation.
package movimento_posizione_pkg;

    typedef enum logic [1:0] {
        ATTESA    = 2'd0,
        CALCOLO_X = 2'd1,
        CALCOLO_Y = 2'd2,
        PUBBLICA  = 2'd3
    } stato_t;

    localparam logic DIR_DESTRA   = 1'b1;
    localparam logic DIR_SINISTRA = 1'b0;
    localparam logic DIR_GIU      = 1'b1;
    localparam logic DIR_SU       = 1'b0;

    // Centre limits keep the whole shape on screen vertically.
    function automatic int limite_y_min(input int altezza);
        return altezza / 2;
    endfunction

    function automatic int limite_y_max(input int v, input int altezza);
        return v - 1 - (altezza / 2);
    endfunction

endpackage

// File: rtl/movimento_posizione_sincronizzatore_impulso.sv
// Two-flop synchroniser for an asynchronous button with a rising-edge
// detector feeding a sticky pending bit that is cleared on request.
module sincronizzatore_impulso (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ingresso_i,
    input  logic cancella_i,
    output logic pendente_o
);

    logic [1:0] sync_q;
    logic       prec_q;
    logic       pend_q;
    logic       pend_d;

    // Synchroniser, edge-history and pending-bit registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
            prec_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ingresso_i};
            prec_q <= sync_q[1];
            pend_q <= pend_d;
        end
    end

    // A fresh edge wins over a clear so a press during consumption survives.
    always_comb begin
        pend_d = pend_q;
        if (sync_q[1] && !prec_q) begin
            pend_d = 1'b1;
        end else if (cancella_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    assign pendente_o = pend_q;

endmodule

// File: rtl/movimento_posizione.sv
// Moves a shape centre once per frame: X wraps around the screen width,
// Y bounces between limits; new values are published during blanking.
module movimento_posizione
    import movimento_posizione_pkg::*;
#(
    parameter int H       = 1280,
    parameter int V       = 1024,
    parameter int ALTEZZA = 100,
    parameter int X_INIT  = 640,
    parameter int Y_INIT  = 512,
    parameter int PASSO   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FRAME_TICK,
    input  logic        CMD_SINISTRA,
    input  logic        CMD_DESTRA,
    input  logic        CMD_SU,
    input  logic        CMD_GIU,
    input  logic        CMD_PAUSA,
    output logic [10:0] X_POS,
    output logic [10:0] Y_POS,
    output logic        DIR_X,
    output logic        DIR_Y,
    output logic        RIMBALZO,
    output logic        AGGIORNATO
);

    localparam logic [11:0] H_W     = 12'(H);
    localparam logic [11:0] PASSO_W = 12'(PASSO);
    localparam logic [11:0] YMIN_W  = 12'(limite_y_min(ALTEZZA));
    localparam logic [11:0] YMAX_W  = 12'(limite_y_max(V, ALTEZZA));

    localparam int P_SIN = 0;
    localparam int P_DES = 1;
    localparam int P_SU  = 2;
    localparam int P_GIU = 3;

    stato_t      stato_q, stato_d;
    logic        tick_q;
    logic [1:0]  pausa_sync_q;
    logic [3:0]  cmd_s;
    logic [3:0]  pend_s;
    logic        cancella_s;
    logic        dx_nuovo_s, dy_nuovo_s;

    logic [11:0] x_calc_q, x_calc_d;
    logic [11:0] y_calc_q, y_calc_d;
    logic        dx_q, dx_d;
    logic        dy_q, dy_d;
    logic        pausa_q, pausa_d;
    logic        flag_rimb_q, flag_rimb_d;

    logic [10:0] x_pos_q, x_pos_d;
    logic [10:0] y_pos_q, y_pos_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic        rimb_q, rimb_d;
    logic        agg_q, agg_d;

    assign cmd_s = {CMD_GIU, CMD_SU, CMD_DESTRA, CMD_SINISTRA};

    for (genvar g = 0; g < 4; g++) begin : g_cmd
        sincronizzatore_impulso u_sinc (
            .clk_i      (CLK),
            .rst_i      (RESET),
            .ingresso_i (cmd_s[g]),
            .cancella_i (cancella_s),
            .pendente_o (pend_s[g])
        );
    end

    // State, working copy of the motion and the published outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stato_q      <= ATTESA;
            tick_q       <= 1'b0;
            pausa_sync_q <= 2'b00;
            x_calc_q     <= 12'(X_INIT);
            y_calc_q     <= 12'(Y_INIT);
            dx_q         <= DIR_DESTRA;
            dy_q         <= DIR_GIU;
            pausa_q      <= 1'b0;
            flag_rimb_q  <= 1'b0;
            x_pos_q      <= 11'(X_INIT);
            y_pos_q      <= 11'(Y_INIT);
            dir_x_q      <= DIR_DESTRA;
            dir_y_q      <= DIR_GIU;
            rimb_q       <= 1'b0;
            agg_q        <= 1'b0;
        end else begin
            stato_q      <= stato_d;
            tick_q       <= FRAME_TICK;
            pausa_sync_q <= {pausa_sync_q[0], CMD_PAUSA};
            x_calc_q     <= x_calc_d;
            y_calc_q     <= y_calc_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            pausa_q      <= pausa_d;
            flag_rimb_q  <= flag_rimb_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            rimb_q       <= rimb_d;
            agg_q        <= agg_d;
        end
    end

    // Opposing requests pending together cancel out.
    always_comb begin
        dx_nuovo_s = dx_q;
        dy_nuovo_s = dy_q;
        if (pend_s[P_SIN] && !pend_s[P_DES]) begin
            dx_nuovo_s = DIR_SINISTRA;
        end else if (pend_s[P_DES] && !pend_s[P_SIN]) begin
            dx_nuovo_s = DIR_DESTRA;
        end else begin
            dx_nuovo_s = dx_q;
        end
        if (pend_s[P_SU] && !pend_s[P_GIU]) begin
            dy_nuovo_s = DIR_SU;
        end else if (pend_s[P_GIU] && !pend_s[P_SU]) begin
            dy_nuovo_s = DIR_GIU;
        end else begin
            dy_nuovo_s = dy_q;
        end
    end

    // Sequencer: one axis per state, then a single publish step.
    always_comb begin
        stato_d     = stato_q;
        cancella_s  = 1'b0;
        x_calc_d    = x_calc_q;
        y_calc_d    = y_calc_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        pausa_d     = pausa_q;
        flag_rimb_d = flag_rimb_q;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        rimb_d      = 1'b0;
        agg_d       = 1'b0;
        case (stato_q)
            ATTESA: begin
                if (tick_q) begin
                    stato_d = CALCOLO_X;
                end else begin
                    stato_d = ATTESA;
                end
            end
            CALCOLO_X: begin
                cancella_s = 1'b1;
                dx_d       = dx_nuovo_s;
                dy_d       = dy_nuovo_s;
                pausa_d    = pausa_sync_q[1];
                if (pausa_sync_q[1]) begin
                    x_calc_d = x_calc_q;
                end else if (dx_nuovo_s == DIR_DESTRA) begin
                    if ((x_calc_q + PASSO_W) >= H_W) begin
                        x_calc_d = x_calc_q + PASSO_W - H_W;
                    end else begin
                        x_calc_d = x_calc_q + PASSO_W;
                    end
                end else begin
                    if (x_calc_q < PASSO_W) begin
                        x_calc_d = x_calc_q + H_W - PASSO_W;
                    end else begin
                        x_calc_d = x_calc_q - PASSO_W;
                    end
                end
                stato_d = CALCOLO_Y;
            end
            CALCOLO_Y: begin
                flag_rimb_d = 1'b0;
                if (pausa_q) begin
                    y_calc_d = y_calc_q;
                end else if (dy_q == DIR_GIU) begin
                    if ((y_calc_q + PASSO_W) >= YMAX_W) begin
                        y_calc_d    = YMAX_W;
                        dy_d        = DIR_SU;
                        flag_rimb_d = 1'b1;
                    end else begin
                        y_calc_d = y_calc_q + PASSO_W;
                    end
                end else begin
                    if (y_calc_q <= (YMIN_W + PASSO_W)) begin
                        y_calc_d    = YMIN_W;
                        dy_d        = DIR_GIU;
                        flag_rimb_d = 1'b1;
                    end else begin
                        y_calc_d = y_calc_q - PASSO_W;
                    end
                end
                stato_d = PUBBLICA;
            end
            PUBBLICA: begin
                x_pos_d = x_calc_q[10:0];
                y_pos_d = y_calc_q[10:0];
                dir_x_d = dx_q;
                dir_y_d = dy_q;
                rimb_d  = flag_rimb_q;
                agg_d   = 1'b1;
                stato_d = ATTESA;
            end
            default: begin
                stato_d = ATTESA;
            end
        endcase
    end

    assign X_POS      = x_pos_q;
    assign Y_POS      = y_pos_q;
    assign DIR_X      = dir_x_q;
    assign DIR_Y      = dir_y_q;
    assign RIMBALZO   = rimb_q;
    assign AGGIORNATO = agg_q;

endmodule
